// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// The optional byte-strobe build is selected with DMEM_BYTE_WRITE_EN.
package dmem_pkg;

    localparam int unsigned DMEM_N       = 16;
    localparam int unsigned DMEM_ADDR_W  = 8;
    localparam int unsigned DMEM_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Misaligned byte address, or any bit set above the word-index field.
    function automatic logic addr_err(input logic [31:0] addr,
                                      input int unsigned n,
                                      input int unsigned addr_w);
        logic err;
        err = addr[0];
        for (int unsigned i = 1; i < 32; i++) begin
            if (i > addr_w && i < n && addr[i]) err = 1'b1;
        end
        return err;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed storage array: synchronous per-lane write, combinational read.
module dmem_ram #(
    parameter int unsigned N      = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LANES  = N / 8
) (
    input  logic              clk,
    input  logic [LANES-1:0]  we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [N-1:0]      wdata,
    output logic [N-1:0]      rdata
);

    logic [N-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        for (int unsigned l = 0; l < LANES; l++) begin
            if (we[l]) mem_q[addr][l*8 +: 8] <= wdata[l*8 +: 8];
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with fixed access latency over valid/ready handshakes.
// Define DMEM_BYTE_WRITE_EN to add the req_be byte-strobe port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned N       = DMEM_N,
    parameter int unsigned ADDR_W  = DMEM_ADDR_W,
    parameter int unsigned LATENCY = DMEM_LATENCY
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
    input  logic [N/8-1:0] req_be,
`endif
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic         busy
);

    localparam int unsigned LANES  = N / 8;
    localparam bit          DIRECT = (LATENCY == 1);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             wr_q;
    logic [N-1:0]     addr_q, wdata_q;
    logic [LANES-1:0] be_q;
    logic [N-1:0]     rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             accept, commit;
    logic             src_write, src_err;
    logic [N-1:0]     src_addr, src_wdata;
    logic [LANES-1:0] src_be, req_be_w, ram_we;
    logic [N-1:0]     ram_rdata;

`ifdef DMEM_BYTE_WRITE_EN
    assign req_be_w = req_be;
`else
    assign req_be_w = '1;
`endif

    assign accept = (state_q == IDLE) && req_valid;

    // With single-cycle latency the commit coincides with acceptance, so the
    // live request fields stand in for the not-yet-loaded captured copy.
    assign commit    = DIRECT ? accept : (state_q == WAIT && cnt_q == 4'd1);
    assign src_write = DIRECT ? req_write : wr_q;
    assign src_addr  = DIRECT ? req_addr  : addr_q;
    assign src_wdata = DIRECT ? req_wdata : wdata_q;
    assign src_be    = DIRECT ? req_be_w  : be_q;

    dmem_ram #(
        .N      (N),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (src_addr[ADDR_W:1]),
        .wdata (src_wdata),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ram_we  = '0;
        src_err = addr_err(32'(src_addr), N, ADDR_W);

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = DIRECT ? RESP : WAIT;
                    cnt_d   = DIRECT ? 4'd0 : 4'(LATENCY - 1);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            err_d   = src_err;
            rdata_d = (!src_write && !src_err) ? ram_rdata : '0;
            if (src_write && !src_err && !reset) ram_we = src_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                be_q    <= req_be_w;
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY=3; byte-strobe cases need DMEM_BYTE_WRITE_EN.
module tb_dmem_responder;

    localparam int unsigned LAT   = 3;
    localparam int unsigned BOUND = 50;

    typedef struct {
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
`ifdef DMEM_BYTE_WRITE_EN
    logic [1:0]  req_be = 2'b11;
`endif
    logic        rsp_ready = 1'b0;
    logic        req_ready, rsp_valid, rsp_err, busy;
    logic [15:0] rsp_rdata;

    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    logic [15:0] mem_m [256];

    always #5 clk = ~clk;

    dmem_responder #(
        .N       (16),
        .ADDR_W  (8),
        .LATENCY (LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_BYTE_WRITE_EN
        .req_be    (req_be),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    // Returns at the first falling edge after the accepting rising edge.
    task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] d,
                         input logic [1:0] be, input bit track);
        exp_t        e;
        int unsigned n;
        logic        err;
        logic [1:0]  ben;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
`ifdef DMEM_BYTE_WRITE_EN
        req_be = be;
        ben    = be;
`else
        ben = be | 2'b11;
`endif
        n = 0;
        while (!req_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout addr=%h req_ready=%b required 1", a, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (track) begin
            err = a[0] | (a[15:9] != 7'd0);
            if (w && !err) begin
                if (ben[0]) mem_m[a[8:1]][7:0]  = d[7:0];
                if (ben[1]) mem_m[a[8:1]][15:8] = d[15:8];
            end
            e.err   = err;
            e.rdata = (w || err) ? 16'h0000 : mem_m[a[8:1]];
            exp_q.push_back(e);
        end
    endtask

    task automatic get_rsp(input string name);
        exp_t        e;
        int unsigned n;
        n = 0;
        while (!rsp_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s rsp_timeout rsp_valid=%b required 1", name, rsp_valid);
            return;
        end
        rsp_ready = 1'b1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected_rsp rdata=%h err=%b", name, rsp_rdata, rsp_err);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (rsp_rdata !== e.rdata) begin
                errors++;
                $display("FAIL %s rdata got=%h required=%h", name, rsp_rdata, e.rdata);
            end
            checks++;
            if (rsp_err !== e.err) begin
                errors++;
                $display("FAIL %s err got=%b required=%b", name, rsp_err, e.err);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_handshake ready/valid/busy got=%b%b%b required=100",
                     name, req_ready, rsp_valid, busy);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
            rsp_rdata !== 16'h0000 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL %s ready=%b valid=%b busy=%b rdata=%h err=%b required 1 0 0 0000 0",
                     name, req_ready, rsp_valid, busy, rsp_rdata, rsp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values");
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        issue(1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b1);
        get_rsp("store_beef");
        issue(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b1);
        get_rsp("load_beef");
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 16'(16'h0100 + 16'(i * 6)), 16'(16'h1357 * (i + 1)), 2'b11, 1'b1);
            get_rsp("store_pattern");
        end
        for (int i = 3; i >= 0; i--) begin
            issue(1'b0, 16'(16'h0100 + 16'(i * 6)), 16'h0000, 2'b11, 1'b1);
            get_rsp("load_pattern");
        end
        issue(1'b1, 16'h01FE, 16'h9A5C, 2'b11, 1'b1);
        get_rsp("store_top_word");
        issue(1'b0, 16'h01FE, 16'h0000, 2'b11, 1'b1);
        get_rsp("load_top_word");
    endtask

    task automatic test_latency();
        issue(1'b0, 16'h0010, 16'h0000, 2'b11, 1'b1);
        for (int k = 1; k < int'(LAT); k++) begin
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL latency_wait k=%0d valid/busy/ready got=%b%b%b required=010",
                         k, rsp_valid, busy, req_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL latency_resp valid/busy/ready got=%b%b%b required=110",
                     rsp_valid, busy, req_ready);
        end
        get_rsp("latency_load");
    endtask

    task automatic test_backpressure();
        int unsigned n;
        issue(1'b1, 16'h0030, 16'hCAFE, 2'b11, 1'b1);
        get_rsp("bp_store");
        issue(1'b0, 16'h0030, 16'h0000, 2'b11, 1'b1);
        n = 0;
        while (!rsp_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 16'h0030;
        req_wdata = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 16'hCAFE ||
                rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cyc=%0d valid=%b ready=%b rdata=%h err=%b required 1 0 cafe 0",
                         i, rsp_valid, req_ready, rsp_rdata, rsp_err);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        get_rsp("bp_load");
        issue(1'b0, 16'h0030, 16'h0000, 2'b11, 1'b1);
        get_rsp("bp_ignored_store");
    endtask

    task automatic test_errors();
        issue(1'b1, 16'h0000, 16'h0F0F, 2'b11, 1'b1);
        get_rsp("err_seed_word0");
        issue(1'b0, 16'h0011, 16'h0000, 2'b11, 1'b1);
        get_rsp("err_misaligned");
        issue(1'b0, 16'h0200, 16'h0000, 2'b11, 1'b1);
        get_rsp("err_range");
        issue(1'b1, 16'h0200, 16'h7777, 2'b11, 1'b1);
        get_rsp("err_store_range");
        issue(1'b1, 16'h8001, 16'h6666, 2'b11, 1'b1);
        get_rsp("err_store_both");
        issue(1'b0, 16'h0000, 16'h0000, 2'b11, 1'b1);
        get_rsp("err_word0_intact");
    endtask

    task automatic test_reset_abort();
        int unsigned n;
        issue(1'b1, 16'h0004, 16'h1111, 2'b11, 1'b1);
        get_rsp("abort_seed");
        issue(1'b1, 16'h0004, 16'h1234, 2'b11, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset_in_wait");
        issue(1'b0, 16'h0004, 16'h0000, 2'b11, 1'b1);
        get_rsp("abort_load");
        issue(1'b0, 16'h0004, 16'h0000, 2'b11, 1'b0);
        n = 0;
        while (!rsp_valid && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset_in_resp");
    endtask

`ifdef DMEM_BYTE_WRITE_EN
    task automatic test_byte_write();
        issue(1'b1, 16'h0040, 16'hAAAA, 2'b11, 1'b1);
        get_rsp("be_seed");
        issue(1'b1, 16'h0040, 16'h5555, 2'b01, 1'b1);
        get_rsp("be_low_store");
        issue(1'b0, 16'h0040, 16'h0000, 2'b11, 1'b1);
        get_rsp("be_low_load");
        issue(1'b1, 16'h0040, 16'h33CC, 2'b10, 1'b1);
        get_rsp("be_high_store");
        issue(1'b1, 16'h0040, 16'hFFFF, 2'b00, 1'b1);
        get_rsp("be_none_store");
        issue(1'b0, 16'h0040, 16'h0000, 2'b11, 1'b1);
        get_rsp("be_final_load");
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_latency();
        test_backpressure();
        test_errors();
        test_reset_abort();
`ifdef DMEM_BYTE_WRITE_EN
        test_byte_write();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover count=%0d required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
